// File: rtl/fixed_activation_arbiter_if.sv
// Bundle of per-requester streaming ports and grant status shared between
// the layer pipelines (master side) and the activation arbiter (slave side).
interface fixed_activation_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][SIZE-1:0][DATA_WIDTH-1:0] data_in_0;
    logic [NUM_REQ-1:0]                           data_in_0_valid;
    logic [NUM_REQ-1:0]                           data_in_0_ready;
    logic [NUM_REQ-1:0][SIZE-1:0][DATA_WIDTH-1:0] data_out_0;
    logic [NUM_REQ-1:0]                           data_out_0_valid;
    logic [NUM_REQ-1:0]                           data_out_0_ready;
    logic                                         grant_valid;
    logic [ID_W-1:0]                              grant_id;

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid,
        input  grant_valid, grant_id
    );

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid,
        output grant_valid, grant_id
    );
endinterface

// File: rtl/fixed_activation_arbiter.sv
// Round-robin burst arbiter sharing one SIZE-lane ReLU datapath between
// NUM_REQ requesters. One registered output stage, tagged with the owner ID.
module fixed_activation_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_WIDTH = 0,
    parameter int SIZE       = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    fixed_activation_arbiter_if.slave   bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    // FRAC_WIDTH only describes the number format; ReLU ignores the binary point.
    if (NUM_REQ < 2 || BURST_LEN < 1 || FRAC_WIDTH < 0 || FRAC_WIDTH > DATA_WIDTH) begin : g_bad_params
        $error("fixed_activation_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                         state, state_nxt;
    logic [ID_W-1:0]                owner, owner_nxt;
    logic [ID_W-1:0]                rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]               beat_cnt, beat_cnt_nxt;
    logic                           out_valid;
    logic [ID_W-1:0]                out_id;
    logic [SIZE-1:0][DATA_WIDTH-1:0] out_data;
    logic [SIZE-1:0][DATA_WIDTH-1:0] relu_data;
    logic                           can_accept;
    logic                           handshake;
    logic                           found;
    logic [ID_W-1:0]                pick;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned inc);
        int unsigned sum;
        sum = 32'(base) + inc;
        return ID_W'(sum % NUM_REQ);
    endfunction

    // Round-robin search starting at rr_ptr for the first valid requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.data_in_0_valid[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_ptr, k);
            end
        end
    end

    // Owner handshake: accept only when the output stage is free or draining.
    always_comb begin
        can_accept          = !out_valid || bus.data_out_0_ready[out_id];
        handshake           = (state == GRANT) && can_accept && bus.data_in_0_valid[owner];
        bus.data_in_0_ready = '0;
        if (state == GRANT && can_accept) begin
            bus.data_in_0_ready[owner] = 1'b1;
        end
    end

    // Lane-wise ReLU on the owner's beat: non-positive values clamp to zero.
    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (bus.data_in_0[owner][i][DATA_WIDTH-1] || bus.data_in_0[owner][i] == '0) begin
                relu_data[i] = '0;
            end else begin
                relu_data[i] = bus.data_in_0[owner][i];
            end
        end
    end

    // Next-state logic: grant on search hit, release on full burst or dropped valid.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt    = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (!bus.data_in_0_valid[owner]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = wrap_add(owner, 1);
                end else if (handshake) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = wrap_add(owner, 1);
                    end
                end
            end
        endcase
    end

    // Output routing: result broadcast on every port, valid only on the tagged one.
    always_comb begin
        bus.data_out_0_valid = '0;
        if (out_valid) begin
            bus.data_out_0_valid[out_id] = 1'b1;
        end
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            bus.data_out_0[r] = out_data;
        end
        bus.grant_valid = (state == GRANT);
        bus.grant_id    = owner;
    end

    // State registers and output stage; a handshake overrides a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (handshake) begin
                out_data  <= relu_data;
                out_id    <= owner;
                out_valid <= 1'b1;
            end else if (out_valid && bus.data_out_0_ready[out_id]) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fixed_activation_arbiter.sv
// Self-checking bench: cycle model of the arbiter compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fixed_activation_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int FRAC_WIDTH = 0;
    localparam int SIZE       = 8;
    localparam int BURST_LEN  = 4;
    localparam int LW         = SIZE * DATA_WIDTH;

    typedef logic [LW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixed_activation_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) bus ();

    fixed_activation_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .FRAC_WIDTH(FRAC_WIDTH),
        .SIZE(SIZE), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t relu_model(input beat_t b);
        beat_t res;
        logic signed [DATA_WIDTH-1:0] v;
        res = '0;
        for (int i = 0; i < SIZE; i++) begin
            v = b[i*DATA_WIDTH +: DATA_WIDTH];
            if (v > 0) res[i*DATA_WIDTH +: DATA_WIDTH] = v;
        end
        return res;
    endfunction

    // ---------------- behavioural model ----------------
    bit    m_granted = 0;
    int    m_owner   = 0;
    int    m_rr      = 0;
    int    m_beats   = 0;
    bit    m_pend_v  = 0;
    int    m_pend_id = 0;
    beat_t m_pend_data = '0;
    bit    m_room, m_take;

    always @(posedge clk) begin
        if (rst) begin
            m_granted = 0; m_owner = 0; m_rr = 0; m_beats = 0;
            m_pend_v = 0; m_pend_id = 0; m_pend_data = '0;
        end else begin
            m_room = !m_pend_v || bus.data_out_0_ready[m_pend_id];
            m_take = m_granted && m_room && bus.data_in_0_valid[m_owner];
            if (m_take) begin
                m_pend_v    = 1;
                m_pend_id   = m_owner;
                m_pend_data = relu_model(bus.data_in_0[m_owner]);
                m_beats++;
            end else if (m_pend_v && bus.data_out_0_ready[m_pend_id]) begin
                m_pend_v = 0;
            end
            if (m_granted) begin
                if (!bus.data_in_0_valid[m_owner] || m_beats == BURST_LEN) begin
                    m_granted = 0;
                    m_rr      = (m_owner + 1) % NUM_REQ;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!m_granted && bus.data_in_0_valid[(m_rr + k) % NUM_REQ]) begin
                        m_granted = 1;
                        m_owner   = (m_rr + k) % NUM_REQ;
                        m_beats   = 0;
                    end
                end
            end
        end
    end

    // ---------------- compare process + observation logs ----------------
    int grant_log[$];
    int beats_log[$];
    int hs_cnt[NUM_REQ];
    int cons_cnt[NUM_REQ];
    int out_seen[NUM_REQ];
    bit prev_gv = 0;
    logic [NUM_REQ-1:0] exp_rdy, exp_ov;
    bit room_n;

    always @(negedge clk) begin
        room_n  = !m_pend_v || bus.data_out_0_ready[m_pend_id];
        exp_rdy = '0;
        if (m_granted && room_n) exp_rdy[m_owner] = 1'b1;
        exp_ov = '0;
        if (m_pend_v) exp_ov[m_pend_id] = 1'b1;
        check("grant_valid", bus.grant_valid, m_granted);
        check("grant_id", bus.grant_id, m_owner);
        check("in_ready", bus.data_in_0_ready, exp_rdy);
        check("out_valid", bus.data_out_0_valid, exp_ov);
        for (int r = 0; r < NUM_REQ; r++) begin
            if (exp_ov[r]) check("data_out", bus.data_out_0[r], m_pend_data);
        end
        if (bus.grant_valid && !prev_gv) begin
            grant_log.push_back(int'(bus.grant_id));
            beats_log.push_back(0);
        end
        prev_gv = bus.grant_valid;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (bus.data_in_0_ready[r] && bus.data_in_0_valid[r]) begin
                hs_cnt[r]++;
                if (beats_log.size() > 0) beats_log[beats_log.size()-1]++;
            end
            if (bus.data_out_0_valid[r] && bus.data_out_0_ready[r]) cons_cnt[r]++;
            if (bus.data_out_0_valid[r]) out_seen[r]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit auto_data = 0;
    int cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_data) begin
            for (int r = 0; r < NUM_REQ; r++)
                for (int i = 0; i < SIZE; i++)
                    bus.data_in_0[r][i] = DATA_WIDTH'(cyc * 29 + i * 53 + r * 17 + 3);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_hs(input int r, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            wait_neg();
            ok = bus.data_in_0_ready[r] && bus.data_in_0_valid[r];
            if (!ok) step();
        end
        check({"wait_hs_", tag}, ok, 1);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        beats_log.delete();
        for (int r = 0; r < NUM_REQ; r++) begin
            hs_cnt[r] = 0; cons_cnt[r] = 0; out_seen[r] = 0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic idle_all(input int n);
        bus.data_in_0_valid = '0;
        repeat (n) step();
    endtask

    // ---------------- directed scenarios ----------------
    beat_t relu_in  = 64'hC0_40_FB_05_7F_00_FF_80;  // {-64,64,-5,5,127,0,-1,-128}
    beat_t relu_exp = 64'h00_40_00_05_7F_00_00_00;
    beat_t held;
    logic [8:0] hs_bits;

    initial begin
        bus.data_in_0        = '0;
        bus.data_in_0_valid  = '0;
        bus.data_out_0_ready = '1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        wait_neg();
        check("rst_grant_valid", bus.grant_valid, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_in_ready", bus.data_in_0_ready, 0);
        check("rst_out_valid", bus.data_out_0_valid, 0);

        // ReLU values on requester 0
        step();
        bus.data_in_0[0]      = relu_in;
        bus.data_in_0_valid[0] = 1'b1;
        wait_hs(0, "relu");
        step();
        bus.data_in_0_valid[0] = 1'b0;
        wait_neg();
        check("relu_out_valid", bus.data_out_0_valid, 4'b0001);
        check("relu_data", bus.data_out_0[0], relu_exp);
        idle_all(4);

        // full burst on requester 1
        auto_data = 1;
        clear_logs();
        bus.data_in_0_valid[1] = 1'b1;
        wait_hs(1, "burst");
        hs_bits = '0;
        for (int j = 0; j < 9; j++) begin
            hs_bits[8-j] = bus.data_in_0_ready[1] && bus.data_in_0_valid[1];
            if (bus.grant_valid) check("burst_grant_id", bus.grant_id, 1);
            step();
            wait_neg();
        end
        check("burst_pattern", hs_bits, 9'b111101111);
        check("burst_grants", grant_log.size(), 2);
        check("burst_beats0", beats_log[0], 4);
        idle_all(4);

        // contention between requesters 0 and 2
        pulse_reset();
        clear_logs();
        bus.data_in_0_valid = 4'b0101;
        repeat (22) step();
        idle_all(4);
        wait_neg();
        check("cont_ge4", grant_log.size() >= 4, 1);
        for (int g = 0; g < 4; g++) begin
            check("cont_order", grant_log[g], (g % 2 == 0) ? 0 : 2);
            check("cont_beats", beats_log[g], 4);
        end
        check("cont_no_out1", out_seen[1], 0);
        check("cont_no_out3", out_seen[3], 0);

        // early release of requester 3 while 0 waits
        pulse_reset();
        clear_logs();
        bus.data_in_0_valid[3] = 1'b1;
        wait_hs(3, "early1");
        step();
        bus.data_in_0_valid[0] = 1'b1;
        wait_hs(3, "early2");
        step();
        bus.data_in_0_valid[3] = 1'b0;
        step();
        bus.data_in_0_valid[3] = 1'b1;
        wait_neg();
        check("early_bubble", bus.grant_valid, 0);
        step();
        wait_neg();
        check("early_next_gv", bus.grant_valid, 1);
        check("early_next_id", bus.grant_id, 0);
        check("early_beats3", beats_log[0], 2);
        idle_all(6);

        // backpressure on requester 1
        pulse_reset();
        clear_logs();
        bus.data_in_0_valid[1] = 1'b1;
        wait_hs(1, "bp1");
        step();
        wait_hs(1, "bp2");
        step();
        bus.data_out_0_ready[1] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_neg();
            if (j == 0) held = bus.data_out_0[1];
            check("bp_out_valid", bus.data_out_0_valid[1], 1);
            check("bp_in_ready", bus.data_in_0_ready[1], 0);
            check("bp_held", bus.data_out_0[1], held);
            step();
        end
        bus.data_out_0_ready[1] = 1'b1;
        repeat (8) step();
        idle_all(4);
        wait_neg();
        check("bp_beats0", beats_log[0], 4);
        check("bp_no_loss", cons_cnt[1], hs_cnt[1]);

        // reset mid-burst on requester 2's second grant
        pulse_reset();
        clear_logs();
        bus.data_in_0_valid[2] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_hs(2, "rb_first");
            step();
        end
        wait_hs(2, "rb_b1");
        step();
        wait_hs(2, "rb_b2");
        step();
        check("rb_pending", bus.data_out_0_valid, 4'b0100);
        rst = 1'b1;
        bus.data_in_0_valid = 4'b1110;
        step();
        rst = 1'b0;
        wait_neg();
        check("rb_out_valid", bus.data_out_0_valid, 0);
        check("rb_in_ready", bus.data_in_0_ready, 0);
        check("rb_gv", bus.grant_valid, 0);
        step();
        wait_neg();
        check("rb_regrant_gv", bus.grant_valid, 1);
        check("rb_regrant_id", bus.grant_id, 1);
        idle_all(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
